// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I decode constants.
//   - Opcode values for the seven instruction classes the core executes.
//   - ALU op-class encodings passed to ALU control.
//   - funct3 codes for the conditional branches.
package rv32_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_R      = 2'b10;
  localparam logic [1:0] ALUOP_I      = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/control_unit_branch_cond.sv
// branch_cond: resolves whether a conditional branch is taken.
//   funct3 : branch kind (instr[14:12])
//   zero   : ALU result-equals-zero flag. The ALU runs SUB for BEQ/BNE and
//            SLT/SLTU for the ordered compares, so "less than" shows up as
//            zero=0 and "greater or equal" as zero=1.
//   taken  : 1 when the branch condition holds; reserved funct3 never takes.
module branch_cond
  import rv32_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ, F3_BGE, F3_BGEU: taken = zero;
      F3_BNE, F3_BLT, F3_BLTU: taken = ~zero;
      default:                 taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: main decoder of the single-cycle RV32I core.
//   clk, rst          : core clock, synchronous active-high reset
//   instr[6:0]        : opcode field
//   funct3, zero      : branch kind and ALU zero flag
//   aluop             : ALU op class (00 add, 01 branch, 10 R, 11 I)
//   Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
//   JALflag, JALRflag : datapath controls
//   halt              : core halted (this cycle's illegal opcode or sticky)
// Decode is purely combinational; the only state is the sticky halt flop.
module control_unit
  import rv32_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] instr,
  input  logic [2:0] funct3,
  input  logic       zero,
  output logic [1:0] aluop,
  output logic       Branch,
  output logic       MemRead,
  output logic       MemtoReg,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       JALflag,
  output logic       JALRflag,
  output logic       halt
);

  logic taken;
  logic halt_now;
  logic halted_q;
  logic d_branch, d_memread, d_memwrite, d_regwrite, d_jal, d_jalr;

  branch_cond u_bcond (
    .funct3 (funct3),
    .zero   (zero),
    .taken  (taken)
  );

  always_comb begin
    aluop      = ALUOP_ADD;
    ALUSrc     = 1'b0;
    MemtoReg   = 1'b0;
    d_branch   = 1'b0;
    d_memread  = 1'b0;
    d_memwrite = 1'b0;
    d_regwrite = 1'b0;
    d_jal      = 1'b0;
    d_jalr     = 1'b0;
    halt_now   = 1'b0;
    case (instr)
      OP_R: begin
        aluop      = ALUOP_R;
        d_regwrite = 1'b1;
      end
      OP_I: begin
        aluop      = ALUOP_I;
        ALUSrc     = 1'b1;
        d_regwrite = 1'b1;
      end
      OP_LOAD: begin
        ALUSrc     = 1'b1;
        MemtoReg   = 1'b1;
        d_memread  = 1'b1;
        d_regwrite = 1'b1;
      end
      OP_STORE: begin
        ALUSrc     = 1'b1;
        d_memwrite = 1'b1;
      end
      OP_BRANCH: begin
        aluop    = ALUOP_BRANCH;
        d_branch = taken;
      end
      OP_JAL: begin
        d_regwrite = 1'b1;
        d_jal      = 1'b1;
      end
      OP_JALR: begin
        ALUSrc     = 1'b1;
        d_regwrite = 1'b1;
        d_jalr     = 1'b1;
      end
      default: halt_now = 1'b1;  // illegal or all-zero opcode
    endcase
  end

  // Once halted, suppress every architectural side effect; the remaining
  // datapath selects are harmless and keep following decode.
  assign Branch   = d_branch   & ~halted_q;
  assign MemRead  = d_memread  & ~halted_q;
  assign MemWrite = d_memwrite & ~halted_q;
  assign RegWrite = d_regwrite & ~halted_q;
  assign JALflag  = d_jal      & ~halted_q;
  assign JALRflag = d_jalr     & ~halted_q;
  assign halt     = halt_now | halted_q;

  // Reset wins over a coincident illegal opcode.
  always_ff @(posedge clk) begin
    if (rst)           halted_q <= 1'b0;
    else if (halt_now) halted_q <= 1'b1;
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed plus randomized check of control_unit against a
// behavioural model. Output vector order:
//   {halt, aluop[1:0], Branch, MemRead, MemtoReg, MemWrite, ALUSrc,
//    RegWrite, JALflag, JALRflag}
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] instr;
  logic [2:0] funct3;
  logic       zero;
  logic [1:0] aluop;
  logic       Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
  logic       JALflag, JALRflag, halt;

  int checks = 0;
  int errors = 0;
  bit m_halted = 1'b0;  // model of the sticky halt state

  control_unit dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .funct3   (funct3),
    .zero     (zero),
    .aluop    (aluop),
    .Branch   (Branch),
    .MemRead  (MemRead),
    .MemtoReg (MemtoReg),
    .MemWrite (MemWrite),
    .ALUSrc   (ALUSrc),
    .RegWrite (RegWrite),
    .JALflag  (JALflag),
    .JALRflag (JALRflag),
    .halt     (halt)
  );

  always #5 clk = ~clk;

  logic [10:0] obs;
  assign obs = {halt, aluop, Branch, MemRead, MemtoReg, MemWrite, ALUSrc,
                RegWrite, JALflag, JALRflag};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    logic [6:0] legal [7];
    legal = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
              7'b1100011, 7'b1101111, 7'b1100111};
    foreach (legal[i]) if (legal[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit br_taken(input logic [2:0] f3, input logic z);
    if (f3 == 3'd0 || f3 == 3'd5 || f3 == 3'd7) return z;
    if (f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd6) return !z;
    return 1'b0;
  endfunction

  // Builds the expected output vector from the instruction-class table.
  function automatic logic [10:0] model(input bit hq, input logic [6:0] op,
                                        input logic [2:0] f3, input logic z);
    bit [1:0] ao = 2'b00;
    bit br = 0, mr = 0, m2r = 0, mw = 0, src = 0, rw = 0, jl = 0, jr = 0;
    bit hn = !is_legal(op);
    if (op == 7'b0110011) begin ao = 2'd2; rw = 1; end
    if (op == 7'b0010011) begin ao = 2'd3; src = 1; rw = 1; end
    if (op == 7'b0000011) begin src = 1; mr = 1; m2r = 1; rw = 1; end
    if (op == 7'b0100011) begin src = 1; mw = 1; end
    if (op == 7'b1100011) begin ao = 2'd1; br = br_taken(f3, z); end
    if (op == 7'b1101111) begin rw = 1; jl = 1; end
    if (op == 7'b1100111) begin src = 1; rw = 1; jr = 1; end
    if (hq) begin br = 0; mr = 0; mw = 0; rw = 0; jl = 0; jr = 0; end
    return {hn | hq, ao, br, mr, m2r, mw, src, rw, jl, jr};
  endfunction

  // Drive at negedge, compare shortly after, then let the edge happen and
  // advance the model halt state.
  task automatic step(input string tag, input bit r, input logic [6:0] op,
                      input logic [2:0] f3, input logic z, input bit do_chk);
    @(negedge clk);
    rst = r; instr = op; funct3 = f3; zero = z;
    #1;
    if (do_chk) chk(tag, 32'(obs), 32'(model(m_halted, op, f3, z)));
    @(posedge clk);
    if (r) m_halted = 1'b0;
    else if (!is_legal(op)) m_halted = 1'b1;
  endtask

  initial begin
    logic [6:0] ops [9];
    ops = '{7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011, 7'b1101111,
            7'b1100111, 7'b1100011, 7'b0000000, 7'b0110111};
    rst = 1'b1; instr = 7'b0110011; funct3 = 3'd0; zero = 1'b0;

    // Bring the flop out of X before the first compare.
    step("init", 1, 7'b0110011, 3'd0, 0, 0);
    step("reset_state", 1, 7'b0110011, 3'd0, 0, 1);
    chk("reset_halt", 32'(halt), 32'd0);

    // 1: legal non-branch sweep
    for (int i = 0; i < 6; i++) step("sweep", 0, ops[i], 3'd0, 0, 1);

    // 2: branch matrix
    for (int f = 0; f < 8; f++)
      for (int z = 0; z < 2; z++)
        step("branch", 0, 7'b1100011, 3'(f), 1'(z), 1);

    // 3: all-zero opcode then R-type while halted
    step("halt_now", 0, 7'b0000000, 3'd0, 0, 1);
    step("halted_r", 0, 7'b0110011, 3'd0, 0, 1);
    chk("halted_rw", 32'(RegWrite), 32'd0);

    // 4: store suppressed, then reset clears
    step("halted_st", 0, 7'b0100011, 3'd0, 0, 1);
    step("rst_pulse", 1, 7'b0100011, 3'd0, 0, 1);
    step("post_rst_st", 0, 7'b0100011, 3'd0, 0, 1);
    chk("post_rst_mw", 32'(MemWrite), 32'd1);

    // 5: reset beats illegal opcode
    step("rst_ill0", 1, 7'b0000000, 3'd0, 0, 1);
    step("rst_ill1", 1, 7'b0000000, 3'd0, 0, 1);
    step("after_rst_i", 0, 7'b0010011, 3'd0, 0, 1);
    chk("after_rst_halt", 32'(halt), 32'd0);

    // 6: other undefined opcodes
    step("undef_37", 0, 7'b0110111, 3'd0, 0, 1);
    step("undef_37_sticky", 0, 7'b0010011, 3'd0, 0, 1);
    step("rst6", 1, 7'b0010011, 3'd0, 0, 1);
    step("undef_7f", 0, 7'b1111111, 3'd0, 0, 1);
    step("undef_7f_sticky", 0, 7'b1100011, 3'd0, 1, 1);

    // Randomized: mostly legal opcodes, occasional illegal ones and resets.
    for (int n = 0; n < 400; n++) begin
      logic [6:0] op;
      bit r;
      int sel = $urandom_range(0, 19);
      if (sel < 14)      op = ops[$urandom_range(0, 6)];
      else if (sel < 15) op = 7'($urandom);
      else if (sel < 16) op = ops[$urandom_range(7, 8)];
      else               op = ops[$urandom_range(0, 6)];
      r = ($urandom_range(0, 7) == 0);
      step("rand", r, op, 3'($urandom), 1'($urandom), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
